// File: rtl/ap4_approx_mul.sv
// Registered 4x4 unsigned approximate multiplier built from four 2x2 blocks where 3x3 yields 7.
// Optional macro AP4_ERR_OUT_EN adds a registered err output (exact minus approximate product).
module ap4_approx_mul #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [7:0]   prod
`ifdef AP4_ERR_OUT_EN
  ,
  output logic [5:0]   err
`endif
);

  if (N != 4) begin : g_bad_width
    $error("ap4_approx_mul: only N=4 is supported");
  end

  // 2x2 block: exact except 3x3, where dropping the carry yields 3'b111
  function automatic logic [2:0] sub_mul(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] m;
    m[0] = x[0] & y[0];
    m[1] = (x[1] & y[0]) | (x[0] & y[1]);
    m[2] = x[1] & y[1];
    return m;
  endfunction

  logic [2:0] m_hh, m_hl, m_lh, m_ll;
  logic [7:0] prod_p0;
  logic [7:0] prod_p1;
  logic       vld_p1;

  // Stage 0: combinational partial-product accumulation
  always_comb begin
    m_hh    = sub_mul(a[3:2], b[3:2]);
    m_hl    = sub_mul(a[3:2], b[1:0]);
    m_lh    = sub_mul(a[1:0], b[3:2]);
    m_ll    = sub_mul(a[1:0], b[1:0]);
    prod_p0 = {1'b0, m_hh, 4'b0000}
            + {3'b000, m_hl, 2'b00}
            + {3'b000, m_lh, 2'b00}
            + {5'b00000, m_ll};
  end

`ifdef AP4_ERR_OUT_EN
  logic [7:0] exact_p0;
  logic [7:0] diff_p0;
  logic [5:0] err_p1;

  always_comb begin
    exact_p0 = a * b;
    diff_p0  = exact_p0 - prod_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_p1 <= '0;
    end else if (in_valid) begin
      err_p1 <= diff_p0[5:0];
    end
  end

  assign err = err_p1;
`endif

  // Stage 1: output register, operands ignored unless in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      prod_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        prod_p1 <= prod_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign prod      = prod_p1;

endmodule

// File: tb/tb_ap4_approx_mul.sv
// Self-checking bench for ap4_approx_mul: directed table, handshake/reset sequences,
// exhaustive sweep and randomized traffic against an error-subtraction reference model.
module tb_ap4_approx_mul;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic [7:0] prod;
`ifdef AP4_ERR_OUT_EN
  logic [5:0] err;
`endif

  int n_vec;
  int n_bad;

  ap4_approx_mul #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .prod     (prod)
`ifdef AP4_ERR_OUT_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product minus 2 (weighted by block position) for every 3x3 digit pair
  function automatic int model(input int x, input int y);
    int r;
    r = x * y;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (((x >> (2 * i)) & 3) == 3 && ((y >> (2 * j)) & 3) == 3)
          r -= 2 << (2 * (i + j));
    return r;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at negedge, sample 1 time unit after the next posedge
  task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         prod;
    int         err;
  } vec_t;

  vec_t tbl[8];
  int   exp_prod;
  int   v;
  int   x;
  int   y;

  initial begin
    tbl[0] = '{4'd5,  4'd6,  30,  0};
    tbl[1] = '{4'd15, 4'd1,  15,  0};
    tbl[2] = '{4'd0,  4'd13, 0,   0};
    tbl[3] = '{4'd2,  4'd3,  6,   0};
    tbl[4] = '{4'd3,  4'd3,  7,   2};
    tbl[5] = '{4'd7,  4'd7,  47,  2};
    tbl[6] = '{4'd12, 4'd12, 112, 32};
    tbl[7] = '{4'd15, 4'd15, 175, 50};
    n_vec = 0;
    n_bad = 0;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'd9;
    b        = 4'd11;
    #12;
    check("reset_prod", prod, 0);
    check("reset_vld", out_valid, 0);
`ifdef AP4_ERR_OUT_EN
    check("reset_err", err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom), 4'($urandom));
      check("idle_vld", out_valid, 0);
      check("idle_prod", prod, 0);
    end

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d_prod", i), prod, tbl[i].prod);
      check($sformatf("tbl%0d_vld", i), out_valid, 1);
`ifdef AP4_ERR_OUT_EN
      check($sformatf("tbl%0d_err", i), err, tbl[i].err);
`endif
    end

    drive(1'b1, 4'd3, 4'd3);
    check("b2b0_prod", prod, 7);
    check("b2b0_vld", out_valid, 1);
    drive(1'b1, 4'd5, 4'd6);
    check("b2b1_prod", prod, 30);
    check("b2b1_vld", out_valid, 1);
    drive(1'b1, 4'd15, 4'd15);
    check("b2b2_prod", prod, 175);
    check("b2b2_vld", out_valid, 1);
    drive(1'b0, 4'd1, 4'd1);
    check("hold_vld", out_valid, 0);
    check("hold_prod", prod, 175);

    // Asynchronous reset mid-cycle with a valid operand pair in flight
    @(negedge clk);
    in_valid = 1'b1;
    a        = 4'd5;
    b        = 4'd6;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_prod", prod, 0);
    check("async_rst_vld", out_valid, 0);
`ifdef AP4_ERR_OUT_EN
    check("async_rst_err", err, 0);
`endif
    @(posedge clk);
    #1;
    check("rst_held_prod", prod, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_vld", out_valid, 0);
    check("post_rst_prod", prod, 0);

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        drive(1'b1, 4'(ia), 4'(ib));
        check($sformatf("sweep_%0dx%0d", ia, ib), prod, model(ia, ib));
        if ((ia * ib - int'(prod)) > 50 || (ia * ib - int'(prod)) < 0)
          check($sformatf("errbound_%0dx%0d", ia, ib), ia * ib - int'(prod), 50);
        if (!((((ia & 3) == 3) || ((ia >> 2) == 3)) && (((ib & 3) == 3) || ((ib >> 2) == 3))))
          check($sformatf("exact_%0dx%0d", ia, ib), prod, ia * ib);
`ifdef AP4_ERR_OUT_EN
        check($sformatf("err_%0dx%0d", ia, ib), err, ia * ib - model(ia, ib));
`endif
      end
    end

    exp_prod = int'(prod);
    for (int i = 0; i < 200; i++) begin
      v = int'($urandom_range(1, 0));
      x = int'($urandom_range(15, 0));
      y = int'($urandom_range(15, 0));
      drive(v[0], 4'(x), 4'(y));
      if (v != 0) exp_prod = model(x, y);
      check($sformatf("rand%0d_vld", i), out_valid, v);
      check($sformatf("rand%0d_prod", i), prod, exp_prod);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
